// File: rtl/spi_master_if.sv
// Signal bundle between the SPI master core, its requester and the SPI slave.
// The master modport is the core's view; the slave modport is the far side.
interface spi_master_if #(
  parameter int unsigned LENGTH = 64
);
  logic              START;
  logic [LENGTH-1:0] TO_SEND;
  logic [LENGTH-1:0] RECEIVED;
  logic              BUSY;
  logic              DONE;
  logic              SCK;
  logic              MOSI;
  logic              SSEL;
  logic              MISO;

  modport master (
    input  START, TO_SEND, MISO,
    output RECEIVED, BUSY, DONE, SCK, MOSI, SSEL
  );

  modport slave (
    output START, TO_SEND, MISO,
    input  RECEIVED, BUSY, DONE, SCK, MOSI, SSEL
  );
endinterface

// File: rtl/spi_master.sv
// Mode-0, MSB-first SPI master moving one LENGTH-bit word per START request.
// SCK/SSEL/BUSY/DONE are registered one cycle behind the state register.
module spi_master #(
  parameter int unsigned LENGTH  = 64,
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned GAP     = 8
) (
  input logic          CLK,
  input logic          RESET,
  spi_master_if.master bus
);
  localparam int unsigned CntMax = (CLK_DIV > GAP) ? CLK_DIV : GAP;
  localparam int unsigned CntW   = (CntMax > 2) ? $clog2(CntMax) : 1;
  localparam int unsigned BitW   = $clog2(LENGTH + 1);

  localparam logic [CntW-1:0] DivLast = CntW'(CLK_DIV - 1);
  localparam logic [CntW-1:0] GapLast = CntW'(GAP - 1);
  localparam logic [BitW-1:0] BitLast = BitW'(LENGTH - 1);

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StSckHi,
    StSckLo,
    StHold,
    StDesel
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [BitW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [LENGTH-1:0] tx_q, tx_d;
  logic [LENGTH-1:0] rx_q, rx_d;
  logic [LENGTH-1:0] received_q, received_d;
  logic              sck_q, sck_d;
  logic              ssel_q, ssel_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              fall;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 1'b1;
    bit_cnt_d  = bit_cnt_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    received_d = received_q;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (bus.START) begin
          tx_d      = bus.TO_SEND;
          bit_cnt_d = '0;
          state_d   = StSetup;
        end
      end
      StSetup: begin
        if (cnt_q == DivLast) begin
          cnt_d   = '0;
          state_d = StSckHi;
        end
      end
      StSckHi: begin
        // The last low phase is absorbed into HOLD so the GAP counts from the last fall.
        if (cnt_q == DivLast) begin
          cnt_d   = '0;
          state_d = (bit_cnt_q == BitLast) ? StHold : StSckLo;
        end
      end
      StSckLo: begin
        if (cnt_q == DivLast) begin
          cnt_d   = '0;
          state_d = StSckHi;
        end
      end
      StHold: begin
        if (cnt_q == GapLast) begin
          cnt_d   = '0;
          state_d = StDesel;
        end
      end
      StDesel: begin
        if (cnt_q == GapLast) begin
          cnt_d   = '0;
          state_d = StIdle;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase

    // First cycle of a low phase is the edge that registers SCK 1->0.
    fall = ((state_q == StSckLo) || (state_q == StHold)) && (cnt_q == '0);
    if (fall) begin
      rx_d      = {rx_q[LENGTH-2:0], bus.MISO};
      tx_d      = {tx_q[LENGTH-2:0], 1'b0};
      bit_cnt_d = bit_cnt_q + 1'b1;
    end

    sck_d  = (state_q == StSckHi);
    ssel_d = !((state_q == StSetup) || (state_q == StSckHi) ||
               (state_q == StSckLo) || (state_q == StHold));
    busy_d = (state_q != StIdle);
    done_d = (state_q == StDesel) && (cnt_q == '0);
    if (done_d) begin
      received_d = rx_q;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      bit_cnt_q  <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      received_q <= '0;
      sck_q      <= 1'b0;
      ssel_q     <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      received_q <= received_d;
      sck_q      <= sck_d;
      ssel_q     <= ssel_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.RECEIVED = received_q;
  assign bus.BUSY     = busy_q;
  assign bus.DONE     = done_q;
  assign bus.SCK      = sck_q;
  assign bus.SSEL     = ssel_q;
  assign bus.MOSI     = tx_q[LENGTH-1];
endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: default-size instance plus a small LENGTH=8 instance,
// with loopback, constant-one and behavioural mode-0 slave MISO sources.
module tb_spi_master;
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_master_if #(.LENGTH(64)) bus ();
  spi_master_if #(.LENGTH(8))  bus8 ();

  spi_master #(.LENGTH(64), .CLK_DIV(4), .GAP(8)) u_dut (
    .CLK   (clk),
    .RESET (rst_n),
    .bus   (bus)
  );

  spi_master #(.LENGTH(8), .CLK_DIV(2), .GAP(1)) u_dut8 (
    .CLK   (clk),
    .RESET (rst_n),
    .bus   (bus8)
  );

  // Behavioural mode-0 slave on the same clock: loads on SSEL fall, samples
  // MOSI after a SCK rise, shifts MISO after a SCK fall.
  logic [63:0] slave_word = '0;
  logic [63:0] sl_tx = '0, sl_rx = '0;
  logic        sl_sck_prev = 1'b0, sl_ssel_prev = 1'b1;
  always @(posedge clk) begin
    sl_sck_prev  <= bus.SCK;
    sl_ssel_prev <= bus.SSEL;
    if (sl_ssel_prev && !bus.SSEL) sl_tx <= slave_word;
    else if (!bus.SSEL && !sl_sck_prev && bus.SCK) sl_rx <= {sl_rx[62:0], bus.MOSI};
    else if (!bus.SSEL && sl_sck_prev && !bus.SCK) sl_tx <= {sl_tx[62:0], 1'b0};
  end

  logic [1:0] miso_mode = 2'd0;  // 0 loopback, 1 slave, 2 constant one
  assign bus.MISO  = (miso_mode == 2'd0) ? bus.MOSI : (miso_mode == 2'd1) ? sl_tx[63] : 1'b1;
  assign bus8.MISO = bus8.MOSI;

  int vec = 0, bad = 0;
  logic [63:0] exp_q[$], got_q[$];
  int          done_at[$];
  logic [7:0]  exp8_q[$], got8_q[$];
  int          done8_at[$];
  int          rise8[$], fall8[$];
  int          n_rise = 0, n_ssel_low = 0, n_mosi1 = 0, n_done = 0;
  logic        sck_prev = 1'b0, sck8_prev = 1'b0;

  // Advance one cycle and sample everything half a cycle after the rising edge.
  task automatic tick();
    @(negedge clk);
    #1;
    if (bus.SCK && !sck_prev) n_rise++;
    sck_prev = bus.SCK;
    if (!bus.SSEL) n_ssel_low++;
    if (bus.MOSI) n_mosi1++;
    if (bus.DONE) begin
      n_done++;
      got_q.push_back(bus.RECEIVED);
      done_at.push_back(cyc);
    end
    if (bus8.SCK && !sck8_prev) rise8.push_back(cyc);
    if (!bus8.SCK && sck8_prev) fall8.push_back(cyc);
    sck8_prev = bus8.SCK;
    if (bus8.DONE) begin
      got8_q.push_back(bus8.RECEIVED);
      done8_at.push_back(cyc);
    end
  endtask

  task automatic start64(input logic [63:0] w, output int k);
    bus.TO_SEND = w;
    bus.START   = 1'b1;
    tick();
    k = cyc;
    bus.START = 1'b0;
  endtask

  task automatic wait_got(input int n, input int budget);
    while (got_q.size() < n && budget > 0) begin
      tick();
      budget--;
    end
  endtask

  task automatic wait_idle(input int budget);
    while (bus.BUSY && budget > 0) begin
      tick();
      budget--;
    end
  endtask

  task automatic test_reset();
    bus.START = 1'b0; bus.TO_SEND = '0; bus8.START = 1'b0; bus8.TO_SEND = '0;
    #2 rst_n = 1'b0;
    repeat (3) tick();
    vec++; if (bus.SSEL !== 1'b1) begin bad++; $display("FAIL reset_ssel got %b want 1", bus.SSEL); end
    vec++; if (bus.SCK !== 1'b0) begin bad++; $display("FAIL reset_sck got %b want 0", bus.SCK); end
    vec++; if (bus.MOSI !== 1'b0) begin bad++; $display("FAIL reset_mosi got %b want 0", bus.MOSI); end
    vec++; if (bus.BUSY !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", bus.BUSY); end
    vec++; if (bus.DONE !== 1'b0) begin bad++; $display("FAIL reset_done got %b want 0", bus.DONE); end
    vec++; if (bus.RECEIVED !== 64'd0) begin
      bad++; $display("FAIL reset_received got %h want 0", bus.RECEIVED);
    end
    vec++; if (bus8.SSEL !== 1'b1) begin bad++; $display("FAIL reset_ssel8 got %b want 1", bus8.SSEL); end
    rst_n = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_loopback();
    int k, base, at;
    logic [63:0] w, got, exp;
    miso_mode = 2'd0;
    w = 64'hDEADBEEF_01234567;
    base = n_rise;
    exp_q.push_back(w);
    start64(w, k);
    tick();
    vec++; if (bus.SSEL !== 1'b0) begin bad++; $display("FAIL loop_ssel_fall got %b want 0", bus.SSEL); end
    vec++; if (bus.BUSY !== 1'b1) begin bad++; $display("FAIL loop_busy_rise got %b want 1", bus.BUSY); end
    vec++; if (bus.MOSI !== 1'b1) begin bad++; $display("FAIL loop_mosi_msb got %b want 1", bus.MOSI); end
    while (cyc < k + 4) tick();
    vec++; if (bus.SCK !== 1'b0) begin bad++; $display("FAIL loop_sck_pre got %b want 0", bus.SCK); end
    tick();
    vec++; if (bus.SCK !== 1'b1) begin bad++; $display("FAIL loop_sck_rise got %b want 1", bus.SCK); end
    wait_got(1, 700);
    if (got_q.size() == 0) begin
      vec++; bad++; $display("FAIL loop_done got no DONE want one within budget");
    end else begin
      got = got_q.pop_front(); at = done_at.pop_front(); exp = exp_q.pop_front();
      vec++; if (got !== exp) begin bad++; $display("FAIL loop_data got %h want %h", got, exp); end
      vec++; if (at - k !== 521) begin bad++; $display("FAIL loop_done_time got %0d want 521", at - k); end
    end
    vec++; if (n_rise - base !== 64) begin
      bad++; $display("FAIL loop_sck_pulses got %0d want 64", n_rise - base);
    end
    wait_idle(50);
    vec++; if (cyc - k !== 529) begin bad++; $display("FAIL loop_busy_fall got %0d want 529", cyc - k); end
  endtask

  task automatic test_slave();
    int k, base;
    logic [63:0] w, got, exp;
    miso_mode = 2'd1;
    slave_word = 64'hA5A5_0F0F_3C3C_FFFF;
    w = {$urandom(), $urandom()};
    base = n_ssel_low;
    exp_q.push_back(slave_word);
    start64(w, k);
    wait_got(1, 700);
    wait_idle(50);
    if (got_q.size() == 0) begin
      vec++; bad++; $display("FAIL slave_done got no DONE want one within budget");
    end else begin
      got = got_q.pop_front(); void'(done_at.pop_front()); exp = exp_q.pop_front();
      vec++; if (got !== exp) begin bad++; $display("FAIL slave_master_rx got %h want %h", got, exp); end
    end
    vec++; if (sl_rx !== w) begin bad++; $display("FAIL slave_slave_rx got %h want %h", sl_rx, w); end
    vec++; if (n_ssel_low - base !== 520) begin
      bad++; $display("FAIL slave_ssel_low got %0d want 520", n_ssel_low - base);
    end
  endtask

  task automatic test_miso_ones();
    int k, base;
    logic [63:0] got, exp;
    miso_mode = 2'd2;
    base = n_mosi1;
    exp_q.push_back({64{1'b1}});
    start64(64'd0, k);
    wait_got(1, 700);
    wait_idle(50);
    if (got_q.size() == 0) begin
      vec++; bad++; $display("FAIL ones_done got no DONE want one within budget");
    end else begin
      got = got_q.pop_front(); void'(done_at.pop_front()); exp = exp_q.pop_front();
      vec++; if (got !== exp) begin bad++; $display("FAIL ones_data got %h want %h", got, exp); end
    end
    vec++; if (n_mosi1 - base !== 0) begin
      bad++; $display("FAIL ones_mosi_high got %0d cycles want 0", n_mosi1 - base);
    end
    miso_mode = 2'd0;
  endtask

  task automatic test_back_to_back();
    int k, base, at;
    logic [63:0] w1, w2, got, exp;
    miso_mode = 2'd0;
    w1 = {$urandom(), $urandom()};
    w2 = {$urandom(), $urandom()};
    base = n_done;
    exp_q.push_back(w1);
    exp_q.push_back(w2);
    start64(w1, k);
    while (cyc < k + 49) tick();
    bus.TO_SEND = ~w1; bus.START = 1'b1; tick(); bus.START = 1'b0;
    while (cyc < k + 524) tick();
    bus.START = 1'b1; tick(); bus.START = 1'b0;
    while (cyc < k + 528) tick();
    bus.TO_SEND = w2; bus.START = 1'b1;
    tick();
    vec++; if (bus.SSEL !== 1'b1) begin bad++; $display("FAIL b2b_ssel_gap got %b want 1", bus.SSEL); end
    bus.TO_SEND = ~w2;
    tick();
    vec++; if (bus.SSEL !== 1'b0) begin bad++; $display("FAIL b2b_ssel_fall got %b want 0", bus.SSEL); end
    bus.START = 1'b0;
    wait_got(2, 1200);
    for (int i = 0; i < 2; i++) begin
      if (got_q.size() == 0) begin
        vec++; bad++; $display("FAIL b2b_done word %0d got no DONE want one", i);
      end else begin
        got = got_q.pop_front(); at = done_at.pop_front(); exp = exp_q.pop_front();
        vec++; if (got !== exp) begin bad++; $display("FAIL b2b_data word %0d got %h want %h", i, got, exp); end
        vec++; if (at - k !== 521 + 529 * i) begin
          bad++; $display("FAIL b2b_done_time word %0d got %0d want %0d", i, at - k, 521 + 529 * i);
        end
      end
    end
    wait_idle(50);
    repeat (20) tick();
    vec++; if (n_done - base !== 2) begin bad++; $display("FAIL b2b_done_count got %0d want 2", n_done - base); end
  endtask

  task automatic test_reset_mid();
    int k, base, at;
    logic [63:0] got;
    miso_mode = 2'd0;
    base = n_done;
    start64(64'hCAFE_F00D_1234_5678, k);
    while (cyc < k + 199) tick();
    rst_n = 1'b0;
    #1;
    vec++; if (bus.SSEL !== 1'b1) begin bad++; $display("FAIL rmid_async_ssel got %b want 1", bus.SSEL); end
    vec++; if (bus.SCK !== 1'b0) begin bad++; $display("FAIL rmid_async_sck got %b want 0", bus.SCK); end
    repeat (3) tick();
    vec++; if (bus.BUSY !== 1'b0) begin bad++; $display("FAIL rmid_busy got %b want 0", bus.BUSY); end
    vec++; if (bus.RECEIVED !== 64'd0) begin
      bad++; $display("FAIL rmid_received got %h want 0", bus.RECEIVED);
    end
    rst_n = 1'b1;
    repeat (600) tick();
    vec++; if (n_done - base !== 0) begin bad++; $display("FAIL rmid_no_done got %0d want 0", n_done - base); end
    exp_q.push_back(64'h1);
    start64(64'h1, k);
    wait_got(1, 700);
    if (got_q.size() == 0) begin
      vec++; bad++; $display("FAIL rmid_after got no DONE want one within budget");
    end else begin
      got = got_q.pop_front(); at = done_at.pop_front();
      vec++; if (got !== exp_q.pop_front()) begin bad++; $display("FAIL rmid_after_data got %h want 1", got); end
      vec++; if (at - k !== 521) begin bad++; $display("FAIL rmid_after_time got %0d want 521", at - k); end
    end
    wait_idle(50);
  endtask

  task automatic test_small();
    int k, at;
    logic [7:0] got;
    rise8.delete();
    fall8.delete();
    exp8_q.push_back(8'h81);
    bus8.TO_SEND = 8'h81;
    bus8.START   = 1'b1;
    tick();
    k = cyc;
    bus8.START = 1'b0;
    for (int b = 100; b > 0 && got8_q.size() == 0; b--) tick();
    if (got8_q.size() == 0) begin
      vec++; bad++; $display("FAIL small_done got no DONE want one within budget");
    end else begin
      got = got8_q.pop_front(); at = done8_at.pop_front();
      vec++; if (got !== exp8_q.pop_front()) begin bad++; $display("FAIL small_data got %h want 81", got); end
      vec++; if (at - k !== 34) begin bad++; $display("FAIL small_done_time got %0d want 34", at - k); end
    end
    vec++; if (rise8.size() !== 8) begin bad++; $display("FAIL small_pulses got %0d want 8", rise8.size()); end
    if (rise8.size() >= 2 && fall8.size() >= 1) begin
      vec++; if (rise8[0] - k !== 3) begin bad++; $display("FAIL small_first_rise got %0d want 3", rise8[0] - k); end
      vec++; if (fall8[0] - rise8[0] !== 2) begin
        bad++; $display("FAIL small_high_phase got %0d want 2", fall8[0] - rise8[0]);
      end
      vec++; if (rise8[1] - fall8[0] !== 2) begin
        bad++; $display("FAIL small_low_phase got %0d want 2", rise8[1] - fall8[0]);
      end
    end else begin
      vec++; bad++; $display("FAIL small_phases got %0d rises want at least 2", rise8.size());
    end
    repeat (5) tick();
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_slave();
    test_miso_ones();
    test_back_to_back();
    test_reset_mid();
    test_small();
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "simulation time limit reached");
  end
endmodule

// File: doc/spi_master.md
# spi_master

SPI master (mode 0, MSB first) that drives one full-word transfer to the on-chip `SPI` slave macro. A single `START` pulse launches the transfer: `TO_SEND` is shifted out on `MOSI` while `MISO` is shifted in, and the captured word is presented on `RECEIVED` with a one-cycle `DONE` strobe. The block sits in the test-chip control path on the 50 MHz system clock and generates `SCK`/`SSEL` by counting `CLK` cycles.

## Interface
Parameters:
- `LENGTH`, 64, word length in bits; must be ≥ 2.
- `CLK_DIV`, 4, `CLK` cycles per `SCK` half-period; must be ≥ 2. The default gives 6.25 MHz `SCK` at 50 MHz.
- `GAP`, 8, `CLK` cycles of `SSEL` hold after the last `SCK` fall, and also the minimum `SSEL`-high time between words; must be ≥ 1.

Ports:
- `CLK` in 1: system clock; all logic runs on its rising edge.
- `RESET` in 1: asynchronous, active-low reset.
- `START` in 1: transfer request, sampled only in IDLE.
- `TO_SEND` in `LENGTH`: word to transmit, latched on the accepted `START` cycle.
- `RECEIVED` out `LENGTH`: last complete word captured from `MISO`.
- `BUSY` out 1: high from the cycle after `START` is accepted until the return to IDLE.
- `DONE` out 1: one-cycle pulse when `RECEIVED` is updated.
- `SCK` out 1: SPI clock; idles low.
- `MOSI` out 1: serial data to the slave.
- `SSEL` out 1: active-low slave select; idles high.
- `MISO` in 1: serial data from the slave. The slave runs on the same `CLK`, so `MISO` is sampled with no synchronizer.

## Operation
- State machine: IDLE → SETUP → SCK_HI ⇄ SCK_LO → HOLD → DESEL → IDLE.
- **IDLE**
  - Outputs: `SSEL`=1, `SCK`=0, `BUSY`=0.
  - When `START`=1, latch `TO_SEND` into the tx shift register, clear the bit counter, then go to SETUP.
- **SETUP** (`CLK_DIV` cycles)
  - `SSEL`=0, `SCK`=0.
  - `MOSI` = tx[`LENGTH`-1], the MSB.
- **SCK_HI** (`CLK_DIV` cycles)
  - `SCK`=1. The slave samples `MOSI` on the rising edge.
- **SCK_LO** (`CLK_DIV` cycles)
  - On the cycle that drives `SCK` 1→0:
    - rx <= {rx[`LENGTH`-2:0], `MISO`};
    - tx shifts left one place, so `MOSI` presents the next bit;
    - bit counter increments.
  - After `LENGTH` falls, go to HOLD; otherwise return to SCK_HI.
- **HOLD** (`GAP` cycles)
  - `SSEL`=0, `SCK`=0.
  - `MOSI` = 0 from the last fall onward.
- **DESEL** (`GAP` cycles)
  - `SSEL`=1, `BUSY`=1.
  - On entry: `RECEIVED` <= rx and `DONE`=1 for exactly one cycle.
- `START` is ignored while `BUSY`=1; no request is queued.
- If `START` is held high, a new word starts on the first IDLE cycle. `TO_SEND` is re-latched at that point.
- `TO_SEND` changes after the latch cycle have no effect on the word in flight.
- `RECEIVED` holds its value between transfers. It changes only at the DESEL entry.
- Reset is asynchronous and active-low (`RESET`=0), and takes effect in any state, including mid-word. Reset values:
  - `SSEL`=1, `SCK`=0, `MOSI`=0;
  - `BUSY`=0, `DONE`=0, `RECEIVED`=0;
  - internal shift registers and counters all 0;
  - state = IDLE.
- Reset mid-word leaves no partial data on `RECEIVED`, and no `DONE` pulse is produced.

## Timing
Let `START` be accepted at `CLK` edge k.
- k+1: `SSEL` falls, `BUSY` rises, `MOSI` = bit `LENGTH`-1.
- Rising edge of bit i (i = 0..`LENGTH`-1): k+1+`CLK_DIV`·(1+2i).
- Falling edge and `MISO` sample of bit i: k+1+`CLK_DIV`·(2+2i).
- Last fall: k+1+2·`LENGTH`·`CLK_DIV`.
- `SSEL` rises, `DONE` pulses, `RECEIVED` updates: k+1+2·`LENGTH`·`CLK_DIV`+`GAP`.
- `BUSY` falls: `GAP` cycles after that.
- Defaults (`LENGTH`=64, `CLK_DIV`=4, `GAP`=8):
  - `DONE` at k+521;
  - `BUSY` low at k+529;
  - earliest next `START` acceptance at k+529.
- `MOSI` is stable for at least `CLK_DIV` cycles before each `SCK` rise and for the full high phase.
- The slave must update `MISO` within `CLK_DIV`-1 cycles of a `SCK` rise.

## Test plan
- Loopback (`MISO` tied to `MOSI`), `TO_SEND`=64'hDEADBEEF_01234567, 1-cycle `START` → 64 `SCK` pulses, `DONE` at k+521, `RECEIVED`=64'hDEADBEEF_01234567.
- Master connected to the `SPI` slave, slave `TO_SEND`=64'hA5A5_0F0F_3C3C_FFFF, master `TO_SEND` random → master `RECEIVED` equals the slave word and slave `RECEIVED` equals the master word; `SSEL` low for exactly 2·64·4+8=520 cycles.
- `MISO` held at 1, `TO_SEND`=0 → `RECEIVED`=all ones; `MOSI` stays 0 throughout.
- Extra `START` pulses at k+50 and k+525 (`BUSY`=1), `START` held high from k+529 → no effect mid-word; the second transfer's `SSEL` falls at k+530 with `TO_SEND` sampled at k+529; exactly two `DONE` pulses.
- Assert `RESET`=0 at k+200 for 3 cycles → `SSEL`=1 and `SCK`=0 immediately (asynchronous), `BUSY`=0, no `DONE`, `RECEIVED` = 0. A following transfer with `TO_SEND`=64'h1 completes normally.
- `CLK_DIV`=2, `GAP`=1, `LENGTH`=8, loopback `TO_SEND`=8'h81 → `DONE` at k+1+32+1=k+34, `RECEIVED`=8'h81, `SCK` high/low phases each 2 cycles.
